// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: arbitration mode, FSM states,
// and a width helper for grant indices.
package mem_port_arbiter_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} lc3b_arb_mode;

  typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// slave = arbiter view; master = requesters plus downstream memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned DATA_WIDTH = 16
);
  localparam int unsigned IDX_W = idx_width(NUM_PORTS);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            req_read;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS*BE_W-1:0]       req_byte_en;
  logic [NUM_PORTS-1:0]            req_resp;
  logic [DATA_WIDTH-1:0]           req_rdata;
  logic                            mem_read;
  logic                            mem_write;
  logic [DATA_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [BE_W-1:0]                 mem_byte_en;
  logic                            mem_resp;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            busy;
  logic [IDX_W-1:0]                grant_id;

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, req_byte_en, mem_resp, mem_rdata,
    output req_resp, req_rdata, mem_read, mem_write, mem_addr, mem_wdata, mem_byte_en,
           busy, grant_id
  );

  modport master (
    output req_read, req_write, req_addr, req_wdata, req_byte_en, mem_resp, mem_rdata,
    input  req_resp, req_rdata, mem_read, mem_write, mem_addr, mem_wdata, mem_byte_en,
           busy, grant_id
  );

endinterface

// File: rtl/mem_port_arbiter_picker.sv
// Combinational rotating priority picker: first requester strictly after start,
// wrapping to 0; start = NUM_PORTS-1 gives plain lowest-index-wins priority.
module arb_priority_picker #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic [NUM_PORTS-1:0] winner,
  output logic [IDX_W-1:0]     win_idx,
  output logic                 valid
);

  always_comb begin
    int unsigned cand;
    cand    = 0;
    winner  = '0;
    win_idx = '0;
    valid   = 1'b0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = (32'(start) + k) % NUM_PORTS;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        winner[cand] = 1'b1;
        win_idx      = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-requester arbiter folding split pipeline memory ports onto one unified port;
// one transaction in flight, response steered only to the granted port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned  NUM_PORTS  = 2,
  parameter int unsigned  DATA_WIDTH = 16,
  parameter lc3b_arb_mode ARB_MODE   = ARB_FIXED
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(NUM_PORTS);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  arb_state_t state, state_next;
  logic [IDX_W-1:0]     grant_id;
  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_PORTS-1:0] req_any;
  logic [NUM_PORTS-1:0] pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_start;
  logic                 in_busy;

  logic                  g_read;
  logic                  g_write;
  logic [DATA_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic [BE_W-1:0]       g_byte_en;

  assign req_any    = bus.req_read | bus.req_write;
  assign pick_start = (ARB_MODE == ARB_RR) ? rr_ptr : LAST_IDX;
  assign in_busy    = (state == ST_BUSY);

  arb_priority_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req     (req_any),
    .start   (pick_start),
    .winner  (pick_onehot),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      rr_ptr   <= LAST_IDX;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && pick_valid)
        grant_id <= pick_idx;
      if (in_busy && bus.mem_resp)
        rr_ptr <= grant_id;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (pick_valid)   state_next = ST_BUSY;
      ST_BUSY: if (bus.mem_resp) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Grant is held until mem_resp, so the mux follows the owner's live inputs.
  always_comb begin
    g_read    = 1'b0;
    g_write   = 1'b0;
    g_addr    = '0;
    g_wdata   = '0;
    g_byte_en = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_id == IDX_W'(i)) begin
        g_read    = bus.req_read[i];
        g_write   = bus.req_write[i];
        g_addr    = bus.req_addr[i*DATA_WIDTH +: DATA_WIDTH];
        g_wdata   = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        g_byte_en = bus.req_byte_en[i*BE_W +: BE_W];
      end
    end
  end

  // A write wins over an illegal simultaneous read on the same port.
  always_comb begin
    bus.busy        = in_busy;
    bus.grant_id    = grant_id;
    bus.mem_write   = in_busy & g_write;
    bus.mem_read    = in_busy & g_read & ~g_write;
    bus.mem_addr    = in_busy ? g_addr    : '0;
    bus.mem_wdata   = in_busy ? g_wdata   : '0;
    bus.mem_byte_en = in_busy ? g_byte_en : '0;
    bus.req_rdata   = bus.mem_rdata;
    bus.req_resp    = '0;
    if (in_busy && bus.mem_resp)
      bus.req_resp[grant_id] = 1'b1;
  end

  logic unused_onehot;
  assign unused_onehot = ^pick_onehot;

endmodule
